// File: rtl/adsr_envelope_if.sv
// ----------------------------------------------------------------------------
// adsr_envelope_if
// Signal bundle between an ADSR envelope generator and its controller.
//   master : drives tick, gate, phase durations, sustain level, wave_in;
//            observes wave_out, env_out, active, done
//   slave  : the envelope generator itself (reverse directions)
// Parameters must match those of the adsr_envelope instance attached.
// ----------------------------------------------------------------------------
interface adsr_envelope_if #(
  parameter int DATA_W = 12,
  parameter int GAIN_W = 12,
  parameter int TIME_W = 12
);
  logic              tick;
  logic              gate;
  logic [TIME_W-1:0] attack_time;
  logic [TIME_W-1:0] decay_time;
  logic [GAIN_W-1:0] sustain_level;
  logic [TIME_W-1:0] release_time;
  logic [DATA_W-1:0] wave_in;
  logic [DATA_W-1:0] wave_out;
  logic [GAIN_W-1:0] env_out;
  logic              active;
  logic              done;

  modport master (
    output tick, gate, attack_time, decay_time, sustain_level, release_time, wave_in,
    input  wave_out, env_out, active, done
  );

  modport slave (
    input  tick, gate, attack_time, decay_time, sustain_level, release_time, wave_in,
    output wave_out, env_out, active, done
  );
endinterface

// File: rtl/adsr_envelope.sv
// ----------------------------------------------------------------------------
// adsr_envelope
// Linear attack/decay/sustain/release gain envelope, advanced on sample ticks,
// applied as a gain to the incoming sample stream.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset (aborts any phase, no fade-out)
//   bus  - adsr_envelope_if.slave:
//          tick, gate, attack/decay/release_time (0 treated as 1),
//          sustain_level (read live), wave_in ->
//          wave_out (registered scaled sample), env_out (registered gain),
//          active (state != IDLE), done (1-clk pulse on RELEASE -> IDLE)
// Build option:
//   ADSR_SIGNED_EN - wave_in/wave_out are two's complement; the product is
//                    signed sample x unsigned gain with an arithmetic shift.
//                    Undefined: unsigned samples.
// ----------------------------------------------------------------------------
module adsr_envelope #(
  parameter int DATA_W = 12,
  parameter int GAIN_W = 12,
  parameter int TIME_W = 12
) (
  input  logic            clk,
  input  logic            rst,
  adsr_envelope_if.slave  bus
);
  localparam logic [GAIN_W-1:0] MAX = '1;
  localparam int QW = (GAIN_W > TIME_W) ? GAIN_W : TIME_W;

  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;

  state_t            state, state_n;
  logic [GAIN_W-1:0] env, env_n;
  logic [GAIN_W-1:0] step, step_n;
  logic [TIME_W-1:0] cnt, cnt_n;
  logic              done_q, done_n;
  logic [DATA_W-1:0] wave_q, wave_n;

  logic [TIME_W-1:0] atk_t, dec_t, rel_t;
  logic [GAIN_W-1:0] atk_step, dec_step, rel_step;
  logic [GAIN_W:0]   sum;
  logic [GAIN_W-1:0] env_up, env_dn;

  // Quotient never exceeds the GAIN_W-wide dividend, so the narrowing is exact.
  function automatic logic [GAIN_W-1:0] div_t(input logic [GAIN_W-1:0] num,
                                               input logic [TIME_W-1:0] den);
    logic [QW-1:0] q;
    q = QW'(num) / QW'(den);
    return q[GAIN_W-1:0];
  endfunction

  assign atk_t = (bus.attack_time  == '0) ? TIME_W'(1) : bus.attack_time;
  assign dec_t = (bus.decay_time   == '0) ? TIME_W'(1) : bus.decay_time;
  assign rel_t = (bus.release_time == '0) ? TIME_W'(1) : bus.release_time;

  assign atk_step = div_t(MAX - env, atk_t);
  assign dec_step = div_t(MAX - bus.sustain_level, dec_t);
  assign rel_step = div_t(env, rel_t);

  // Saturating envelope arithmetic
  assign sum    = {1'b0, env} + {1'b0, step};
  assign env_up = sum[GAIN_W] ? MAX : sum[GAIN_W-1:0];
  assign env_dn = (step > env) ? '0 : env - step;

  always_comb begin
    state_n = state;
    env_n   = env;
    cnt_n   = cnt;
    step_n  = step;
    done_n  = 1'b0;
    if (bus.tick) begin
      case (state)
        IDLE: begin
          env_n = '0;
          if (bus.gate) begin
            state_n = ATTACK;
            cnt_n   = atk_t;
            step_n  = atk_step;
          end
        end
        ATTACK: begin
          if (!bus.gate) begin
            state_n = RELEASE;
            cnt_n   = rel_t;
            step_n  = rel_step;
          end else if (cnt == TIME_W'(1)) begin
            env_n   = MAX;
            state_n = DECAY;
            cnt_n   = dec_t;
            step_n  = dec_step;
          end else begin
            env_n = env_up;
            cnt_n = cnt - TIME_W'(1);
          end
        end
        DECAY: begin
          if (!bus.gate) begin
            state_n = RELEASE;
            cnt_n   = rel_t;
            step_n  = rel_step;
          end else if (cnt == TIME_W'(1)) begin
            env_n   = bus.sustain_level;
            state_n = SUSTAIN;
          end else begin
            env_n = env_dn;
            cnt_n = cnt - TIME_W'(1);
          end
        end
        SUSTAIN: begin
          // On key release the envelope keeps its current value and the
          // release ramp is loaded from it.
          if (!bus.gate) begin
            state_n = RELEASE;
            cnt_n   = rel_t;
            step_n  = rel_step;
          end else begin
            env_n = bus.sustain_level;
          end
        end
        RELEASE: begin
          if (bus.gate) begin
            state_n = ATTACK;
            cnt_n   = atk_t;
            step_n  = atk_step;
          end else if (cnt == TIME_W'(1)) begin
            env_n   = '0;
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            env_n = env_dn;
            cnt_n = cnt - TIME_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

`ifdef ADSR_SIGNED_EN
  logic signed [DATA_W+GAIN_W:0] prod;
  assign prod   = $signed({{(GAIN_W+1){bus.wave_in[DATA_W-1]}}, bus.wave_in}) *
                  $signed({{(DATA_W+1){1'b0}}, env});
  assign wave_n = DATA_W'(prod >>> GAIN_W);
`else
  logic [DATA_W+GAIN_W-1:0] prod;
  assign prod   = {{GAIN_W{1'b0}}, bus.wave_in} * {{DATA_W{1'b0}}, env};
  assign wave_n = DATA_W'(prod >> GAIN_W);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      env    <= '0;
      cnt    <= '0;
      step   <= '0;
      done_q <= 1'b0;
      wave_q <= '0;
    end else begin
      state  <= state_n;
      env    <= env_n;
      cnt    <= cnt_n;
      step   <= step_n;
      done_q <= done_n;
      wave_q <= wave_n;
    end
  end

  assign bus.env_out  = env;
  assign bus.wave_out = wave_q;
  assign bus.done     = done_q;
  assign bus.active   = (state != IDLE);
endmodule

// File: tb/tb_adsr_envelope.sv
// ----------------------------------------------------------------------------
// tb_adsr_envelope
// Directed scenarios with hand-derived envelope values, followed by a long
// randomized run checked against a phase-level reference model that tracks
// the envelope as ramps from a start value in fixed integer steps.
// ----------------------------------------------------------------------------
module tb_adsr_envelope;
  localparam int DATA_W = 12;
  localparam int GAIN_W = 12;
  localparam int TIME_W = 12;
  localparam int MAXV   = (1 << GAIN_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adsr_envelope_if #(.DATA_W(DATA_W), .GAIN_W(GAIN_W), .TIME_W(TIME_W)) bus ();

  adsr_envelope #(.DATA_W(DATA_W), .GAIN_W(GAIN_W), .TIME_W(TIME_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  typedef enum {PH_IDLE, PH_ATTACK, PH_DECAY, PH_SUSTAIN, PH_RELEASE} ph_e;
  ph_e m_ph   = PH_IDLE;
  int  m_env  = 0;
  int  m_left = 0;   // ticks remaining in the current ramp
  int  m_step = 0;
  int  m_wave = 0;
  bit  m_done = 0;

  function automatic int dur(input int t);
    return (t == 0) ? 1 : t;
  endfunction

  task automatic start_ramp(input ph_e p, input int t, input int span);
    m_ph   = p;
    m_left = dur(t);
    m_step = span / dur(t);
  endtask

  task automatic model_edge();
    longint prod;
    if (rst) begin
      m_ph = PH_IDLE; m_env = 0; m_left = 0; m_step = 0; m_wave = 0; m_done = 0;
      return;
    end
`ifdef ADSR_SIGNED_EN
    prod   = longint'($signed(bus.wave_in)) * longint'(m_env);
    m_wave = int'(prod >>> GAIN_W);
`else
    prod   = longint'(bus.wave_in) * longint'(m_env);
    m_wave = int'(prod >> GAIN_W);
`endif
    m_done = 0;
    if (!bus.tick) return;
    case (m_ph)
      PH_IDLE: begin
        m_env = 0;
        if (bus.gate) start_ramp(PH_ATTACK, int'(bus.attack_time), MAXV);
      end
      PH_ATTACK: begin
        if (!bus.gate) start_ramp(PH_RELEASE, int'(bus.release_time), m_env);
        else if (m_left == 1) begin
          m_env = MAXV;
          start_ramp(PH_DECAY, int'(bus.decay_time), MAXV - int'(bus.sustain_level));
        end else begin
          m_env = (m_env + m_step > MAXV) ? MAXV : m_env + m_step;
          m_left--;
        end
      end
      PH_DECAY: begin
        if (!bus.gate) start_ramp(PH_RELEASE, int'(bus.release_time), m_env);
        else if (m_left == 1) begin
          m_env = int'(bus.sustain_level);
          m_ph  = PH_SUSTAIN;
        end else begin
          m_env = (m_env - m_step < 0) ? 0 : m_env - m_step;
          m_left--;
        end
      end
      PH_SUSTAIN: begin
        if (!bus.gate) start_ramp(PH_RELEASE, int'(bus.release_time), m_env);
        else m_env = int'(bus.sustain_level);
      end
      PH_RELEASE: begin
        if (bus.gate) start_ramp(PH_ATTACK, int'(bus.attack_time), MAXV - m_env);
        else if (m_left == 1) begin
          m_env  = 0;
          m_ph   = PH_IDLE;
          m_done = 1;
        end else begin
          m_env = (m_env - m_step < 0) ? 0 : m_env - m_step;
          m_left--;
        end
      end
      default: m_ph = PH_IDLE;
    endcase
  endtask

  // One clock: model sees the same inputs the DUT samples, outputs read 1 ns later.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    cycle();
    checks++; if (bus.env_out !== '0) begin errors++; $display("FAIL reset_env got=%0d want=0", bus.env_out); end
    checks++; if (bus.wave_out !== '0) begin errors++; $display("FAIL reset_wave got=%0d want=0", bus.wave_out); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus.done); end
    checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL reset_active got=%b want=0", bus.active); end
    rst = 1'b0;
  endtask

  task automatic test_attack_decay();
    int exp_env [9] = '{0, 1023, 2046, 3069, 4095, 3072, 2048, 2048, 2048};
    bus.attack_time = 4; bus.decay_time = 2; bus.sustain_level = 2048;
    bus.release_time = 4; bus.tick = 1'b1; bus.gate = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cycle();
      checks++; if (bus.env_out !== GAIN_W'(exp_env[i])) begin errors++;
        $display("FAIL ad_env[%0d] got=%0d want=%0d", i, bus.env_out, exp_env[i]); end
      checks++; if (bus.active !== 1'b1) begin errors++;
        $display("FAIL ad_active[%0d] got=%b want=1", i, bus.active); end
    end
  endtask

  task automatic test_release();
    int exp_env [5] = '{2048, 1536, 1024, 512, 0};
    bit exp_dn  [5] = '{0, 0, 0, 0, 1};
    bus.gate = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++; if (bus.env_out !== GAIN_W'(exp_env[i])) begin errors++;
        $display("FAIL rel_env[%0d] got=%0d want=%0d", i, bus.env_out, exp_env[i]); end
      checks++; if (bus.done !== exp_dn[i]) begin errors++;
        $display("FAIL rel_done[%0d] got=%b want=%b", i, bus.done, exp_dn[i]); end
    end
    cycle();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rel_done_after got=%b want=0", bus.done); end
    checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL rel_active_after got=%b want=0", bus.active); end
  endtask

  task automatic test_retrigger_tick_gating();
    int exp_env [3] = '{1536, 2815, 4095};
    bus.attack_time = 4; bus.gate = 1'b1;
    repeat (7) cycle();
    checks++; if (bus.env_out !== GAIN_W'(2048)) begin errors++;
      $display("FAIL rt_sustain got=%0d want=2048", bus.env_out); end
    bus.gate = 1'b0; bus.release_time = 4;
    repeat (2) cycle();
    checks++; if (bus.env_out !== GAIN_W'(1536)) begin errors++;
      $display("FAIL rt_mid_release got=%0d want=1536", bus.env_out); end
    bus.tick = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++; if (bus.env_out !== GAIN_W'(1536) || bus.active !== 1'b1) begin errors++;
        $display("FAIL tick_freeze[%0d] env=%0d active=%b want env=1536 active=1", i, bus.env_out, bus.active); end
    end
    bus.tick = 1'b1; bus.gate = 1'b1; bus.attack_time = 2;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (bus.env_out !== GAIN_W'(exp_env[i])) begin errors++;
        $display("FAIL retrig_env[%0d] got=%0d want=%0d", i, bus.env_out, exp_env[i]); end
    end
  endtask

  task automatic test_live_sustain();
    repeat (2) cycle();   // DECAY 4095 -> 3072 -> 2048 (SUSTAIN)
    checks++; if (bus.env_out !== GAIN_W'(2048)) begin errors++;
      $display("FAIL live_pre got=%0d want=2048", bus.env_out); end
    bus.sustain_level = 1000;
    cycle();
    checks++; if (bus.env_out !== GAIN_W'(1000)) begin errors++;
      $display("FAIL live_sustain got=%0d want=1000", bus.env_out); end
    bus.gate = 1'b0; bus.release_time = 4;
    repeat (5) cycle();   // 1000, 750, 500, 250, 0
    checks++; if (bus.env_out !== '0 || bus.done !== 1'b1) begin errors++;
      $display("FAIL live_release_end env=%0d done=%b want env=0 done=1", bus.env_out, bus.done); end
  endtask

  task automatic test_zero_times();
    int exp_env [5] = '{0, 4095, 2048, 2048, 0};
    bus.attack_time = 0; bus.decay_time = 0; bus.release_time = 0;
    bus.sustain_level = 2048;
    for (int i = 0; i < 5; i++) begin
      bus.gate = (i < 3);
      cycle();
      checks++; if (bus.env_out !== GAIN_W'(exp_env[i])) begin errors++;
        $display("FAIL zero_env[%0d] got=%0d want=%0d", i, bus.env_out, exp_env[i]); end
    end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL zero_done got=%b want=1", bus.done); end
  endtask

  task automatic test_scaling();
    bus.wave_in = 12'hFFF; bus.gate = 1'b0; bus.tick = 1'b1;
    cycle();
    checks++; if (bus.wave_out !== '0) begin errors++;
      $display("FAIL scale_zero_env got=%0d want=0", bus.wave_out); end
    bus.gate = 1'b1;
    repeat (2) cycle();   // ATTACK at 0, then 4095 (DECAY)
    bus.tick = 1'b0;
    cycle();
`ifdef ADSR_SIGNED_EN
    checks++; if (bus.wave_out !== 12'hFFF) begin errors++;
      $display("FAIL scale_signed_m1 got=%0h want=fff", bus.wave_out); end
    bus.tick = 1'b1;
    cycle();              // SUSTAIN at 2048
    bus.tick = 1'b0; bus.wave_in = 12'h800;
    cycle();
    checks++; if (bus.wave_out !== 12'hC00) begin errors++;
      $display("FAIL scale_signed got=%0h want=c00", bus.wave_out); end
`else
    checks++; if (bus.wave_out !== GAIN_W'(4094)) begin errors++;
      $display("FAIL scale_full got=%0d want=4094", bus.wave_out); end
`endif
    bus.tick = 1'b1; bus.gate = 1'b0; bus.wave_in = '0;
    repeat (2) cycle();
    checks++; if (bus.active !== 1'b0) begin errors++;
      $display("FAIL scale_back_idle got=%b want=0", bus.active); end
  endtask

  task automatic test_reset_mid_attack();
    bus.attack_time = 4; bus.decay_time = 2; bus.release_time = 0;
    bus.gate = 1'b1; bus.wave_in = 12'hFFF;
    repeat (3) cycle();
    checks++; if (bus.env_out !== GAIN_W'(2046)) begin errors++;
      $display("FAIL rma_pre got=%0d want=2046", bus.env_out); end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++; if (bus.env_out !== '0 || bus.wave_out !== '0 || bus.done !== 1'b0 || bus.active !== 1'b0) begin
      errors++;
      $display("FAIL rma_reset env=%0d wave=%0d done=%b active=%b want all 0",
               bus.env_out, bus.wave_out, bus.done, bus.active);
    end
    cycle();
    checks++; if (bus.active !== 1'b1 || bus.env_out !== '0) begin errors++;
      $display("FAIL rma_reenter active=%b env=%0d want active=1 env=0", bus.active, bus.env_out); end
    cycle();
    checks++; if (bus.env_out !== GAIN_W'(1023)) begin errors++;
      $display("FAIL rma_first_step got=%0d want=1023", bus.env_out); end
    bus.gate = 1'b0;
    repeat (2) cycle();
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] exp_w;
    for (int i = 0; i < 3000; i++) begin
      rst               = ($urandom_range(0, 299) == 0);
      bus.tick          = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) bus.gate = ~bus.gate;
      bus.attack_time   = TIME_W'($urandom_range(0, 6));
      bus.decay_time    = TIME_W'($urandom_range(0, 6));
      bus.release_time  = TIME_W'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) bus.sustain_level = GAIN_W'($urandom_range(0, MAXV));
      bus.wave_in       = DATA_W'($urandom);
      cycle();
      exp_w = m_wave[DATA_W-1:0];
      checks++; if (bus.env_out !== GAIN_W'(m_env)) begin errors++;
        $display("FAIL rnd_env[%0d] got=%0d want=%0d", i, bus.env_out, m_env); end
      checks++; if (bus.wave_out !== exp_w) begin errors++;
        $display("FAIL rnd_wave[%0d] got=%0h want=%0h", i, bus.wave_out, exp_w); end
      checks++; if (bus.done !== m_done) begin errors++;
        $display("FAIL rnd_done[%0d] got=%b want=%b", i, bus.done, m_done); end
      checks++; if (bus.active !== (m_ph != PH_IDLE)) begin errors++;
        $display("FAIL rnd_active[%0d] got=%b want=%b", i, bus.active, (m_ph != PH_IDLE)); end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.tick = 1'b0; bus.gate = 1'b0;
    bus.attack_time = '0; bus.decay_time = '0; bus.release_time = '0;
    bus.sustain_level = '0; bus.wave_in = '0;
    test_reset();
    test_attack_decay();
    test_release();
    test_retrigger_tick_gating();
    test_live_sustain();
    test_zero_times();
    test_scaling();
    test_reset_mid_attack();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
